// File: rtl/booth_pkg.sv
// Shared constants for the radix-4 Booth multiplier datapath: operand width,
// control-strobe bit positions and the Booth digit encodings seen on q_lsb.
package booth_pkg;

  localparam int unsigned BOOTH_WIDTH = 8;
  localparam int unsigned NUM_CTRL    = 8;

  localparam int unsigned C_LOAD_M = 0;
  localparam int unsigned C_LOAD_Q = 1;
  localparam int unsigned C_ADD    = 2;
  localparam int unsigned C_SUB    = 3;
  localparam int unsigned C_DBL    = 4;
  localparam int unsigned C_SHIFT  = 5;
  localparam int unsigned C_OUT_A  = 6;
  localparam int unsigned C_OUT_Q  = 7;

  // {Q[1],Q[0],Q[-1]} -> multiple of M to accumulate before the shift
  typedef enum logic [2:0] {
    DIG_ZERO_L   = 3'b000,
    DIG_PLUS1_A  = 3'b001,
    DIG_PLUS1_B  = 3'b010,
    DIG_PLUS2    = 3'b011,
    DIG_MINUS2   = 3'b100,
    DIG_MINUS1_A = 3'b101,
    DIG_MINUS1_B = 3'b110,
    DIG_ZERO_H   = 3'b111
  } booth_digit_e;

endpackage

// File: rtl/booth_datapath_addsub.sv
// Combinational Booth operand path: selects M or 2M (sign-extended), optionally
// negates it, and adds it to the accumulator with wrapping arithmetic.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             sub,
  input  logic             dbl,
  output logic [WIDTH+1:0] sum_c
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] m_ext;
  logic [AW-1:0] op;
  logic [AW-1:0] op_inv;

  assign m_ext  = {{2{m[WIDTH-1]}}, m};
  assign op     = dbl ? {m_ext[AW-2:0], 1'b0} : m_ext;
  assign op_inv = op ^ {AW{sub}};
  // Invert-plus-one gives the two's complement when subtracting
  assign sum_c  = a + op_inv + AW'(sub);

endmodule

// File: rtl/booth_datapath.sv
// Radix-4 Booth multiplier register datapath driven by reg_fsm strobes c0..c7.
// Optional product-zero flag is built when BOOTH_ZERO_FLAG_EN is defined.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = BOOTH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inbus,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             c5,
  input  logic             c6,
  input  logic             c7,
  output logic [2:0]       q_lsb,
  output logic [WIDTH-1:0] outbus,
  output logic             zero
);

  localparam int unsigned AW = WIDTH + 2;

  logic [NUM_CTRL-1:0] ctrl;
  logic [AW-1:0]       a, a_d, a_mid, sum_c;
  logic [WIDTH-1:0]    q, q_d, m, m_d, outbus_d;
  logic                qm1, qm1_d;
  booth_digit_e        digit;

  assign ctrl  = {c7, c6, c5, c4, c3, c2, c1, c0};
  assign digit = booth_digit_e'({q[1], q[0], qm1});
  assign q_lsb = digit;

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a),
    .m     (m),
    .sub   (ctrl[C_SUB]),
    .dbl   (ctrl[C_DBL]),
    .sum_c (sum_c)
  );

  assign a_mid = ctrl[C_ADD] ? sum_c : a;

  // Next-state: loads win over arithmetic; a fused add+shift shifts the sum
  always_comb begin
    a_d      = a;
    q_d      = q;
    qm1_d    = qm1;
    m_d      = m;
    outbus_d = outbus;
    if (ctrl[C_LOAD_M] || ctrl[C_LOAD_Q]) begin
      if (ctrl[C_LOAD_M]) begin
        m_d   = inbus;
        a_d   = '0;
        qm1_d = 1'b0;
      end
      if (ctrl[C_LOAD_Q]) begin
        q_d = inbus;
      end
    end else if (ctrl[C_SHIFT]) begin
      a_d   = {{2{a_mid[AW-1]}}, a_mid[AW-1:2]};
      q_d   = {a_mid[1:0], q[WIDTH-1:2]};
      qm1_d = q[1];
    end else begin
      a_d = a_mid;
    end
    if (ctrl[C_OUT_A]) begin
      outbus_d = a[WIDTH-1:0];
    end else if (ctrl[C_OUT_Q]) begin
      outbus_d = q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      m      <= '0;
      outbus <= '0;
    end else begin
      a      <= a_d;
      q      <= q_d;
      qm1    <= qm1_d;
      m      <= m_d;
      outbus <= outbus_d;
    end
  end

`ifdef BOOTH_ZERO_FLAG_EN
  logic update_c;

  assign update_c = ctrl[C_LOAD_M] | ctrl[C_LOAD_Q] | ctrl[C_ADD] | ctrl[C_SHIFT];

  always_ff @(posedge clk) begin
    if (reset) begin
      zero <= 1'b0;
    end else begin
      zero <= update_c && ({a_d[WIDTH-1:0], q_d} == '0);
    end
  end
`else
  assign zero = 1'b0;
`endif

endmodule
